// File: rtl/arbitro_memoria_pkg.sv
// Shared definitions for the memory bus arbiter: FSM states, requester
// indices and default widths.
package arbitro_memoria_pkg;

  typedef enum logic [1:0] {
    LIBRE     = 2'd0,
    ACCESO    = 2'd1,
    RESPUESTA = 2'd2
  } estado_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATO  = 1'b1;

  localparam int ANCHO_DIR_DEF     = 16;
  localparam int ANCHO_DATO_DEF    = 16;
  localparam int LIMITE_ESPERA_DEF = 15;
  // Wide enough for any wait limit up to 255.
  localparam int ANCHO_CONT        = 8;

endpackage

// File: rtl/arbitro_memoria_contador.sv
// Wait-state counter for the arbiter: clear has priority over enable and the
// terminal flag marks the last cycle allowed before a timeout abort.
module contador_espera
  import arbitro_memoria_pkg::*;
#(
  parameter int LIMITE = LIMITE_ESPERA_DEF
) (
  input  logic i_reloj,
  input  logic i_reiniciar_n,
  input  logic i_limpiar,
  input  logic i_habilitar,
  output logic o_terminal
);

  localparam logic [ANCHO_CONT-1:0] TERMINAL = ANCHO_CONT'(LIMITE - 1);
  localparam logic [ANCHO_CONT-1:0] UNO      = ANCHO_CONT'(1);

  logic [ANCHO_CONT-1:0] r_cuenta;

  always_ff @(posedge i_reloj) begin
    if (!i_reiniciar_n) begin
      r_cuenta <= '0;
    end else if (i_limpiar) begin
      r_cuenta <= '0;
    end else if (i_habilitar) begin
      r_cuenta <= r_cuenta + UNO;
    end
  end

  assign o_terminal = (r_cuenta == TERMINAL);

endmodule

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter sequencing instruction fetch and data accesses onto a
// single-port memory bus, with a wait-state timeout that aborts hung accesses.
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int ANCHO_DIR     = ANCHO_DIR_DEF,
  parameter int ANCHO_DATO    = ANCHO_DATO_DEF,
  parameter int LIMITE_ESPERA = LIMITE_ESPERA_DEF
) (
  input  logic                  Reloj,
  input  logic                  Reiniciar,
  input  logic                  SolFetch,
  input  logic [ANCHO_DIR-1:0]  DirFetch,
  output logic                  AckFetch,
  input  logic                  SolDato,
  input  logic                  EscDato,
  input  logic [ANCHO_DIR-1:0]  DirDato,
  input  logic [ANCHO_DATO-1:0] DatoEsc,
  output logic                  AckDato,
  output logic [ANCHO_DATO-1:0] DatoLeido,
  output logic                  ErrorBus,
  output logic                  MemHab,
  output logic                  MemEsc,
  output logic [ANCHO_DIR-1:0]  MemDir,
  output logic [ANCHO_DATO-1:0] MemDatoEsc,
  input  logic                  MemListo,
  input  logic [ANCHO_DATO-1:0] MemDatoLeido
);

  estado_t               r_estado;
  logic                  r_ultimo;
  logic                  r_grant;
  logic                  r_mem_hab;
  logic                  r_mem_esc;
  logic [ANCHO_DIR-1:0]  r_mem_dir;
  logic [ANCHO_DATO-1:0] r_mem_dato_esc;
  logic [ANCHO_DATO-1:0] r_dato_leido;
  logic                  r_ack_fetch;
  logic                  r_ack_dato;
  logic                  r_error;

  estado_t               w_estado_sig;
  logic                  w_ultimo;
  logic                  w_grant;
  logic                  w_mem_hab;
  logic                  w_mem_esc;
  logic [ANCHO_DIR-1:0]  w_mem_dir;
  logic [ANCHO_DATO-1:0] w_mem_dato_esc;
  logic [ANCHO_DATO-1:0] w_dato_leido;
  logic                  w_ack_fetch;
  logic                  w_ack_dato;
  logic                  w_error;
  logic                  w_cont_limpiar;
  logic                  w_cont_hab;
  logic                  w_cont_terminal;

  contador_espera #(
    .LIMITE(LIMITE_ESPERA)
  ) u_contador (
    .i_reloj      (Reloj),
    .i_reiniciar_n(Reiniciar),
    .i_limpiar    (w_cont_limpiar),
    .i_habilitar  (w_cont_hab),
    .o_terminal   (w_cont_terminal)
  );

  always_ff @(posedge Reloj) begin
    if (!Reiniciar) begin
      r_estado       <= LIBRE;
      r_ultimo       <= REQ_DATO;
      r_grant        <= REQ_FETCH;
      r_mem_hab      <= 1'b0;
      r_mem_esc      <= 1'b0;
      r_mem_dir      <= '0;
      r_mem_dato_esc <= '0;
      r_dato_leido   <= '0;
      r_ack_fetch    <= 1'b0;
      r_ack_dato     <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_estado       <= w_estado_sig;
      r_ultimo       <= w_ultimo;
      r_grant        <= w_grant;
      r_mem_hab      <= w_mem_hab;
      r_mem_esc      <= w_mem_esc;
      r_mem_dir      <= w_mem_dir;
      r_mem_dato_esc <= w_mem_dato_esc;
      r_dato_leido   <= w_dato_leido;
      r_ack_fetch    <= w_ack_fetch;
      r_ack_dato     <= w_ack_dato;
      r_error        <= w_error;
    end
  end

  // Acks and ErrorBus default low, so they only survive the single RESPUESTA cycle.
  always_comb begin
    w_estado_sig   = r_estado;
    w_ultimo       = r_ultimo;
    w_grant        = r_grant;
    w_mem_hab      = r_mem_hab;
    w_mem_esc      = r_mem_esc;
    w_mem_dir      = r_mem_dir;
    w_mem_dato_esc = r_mem_dato_esc;
    w_dato_leido   = r_dato_leido;
    w_ack_fetch    = 1'b0;
    w_ack_dato     = 1'b0;
    w_error        = 1'b0;
    w_cont_limpiar = 1'b0;
    w_cont_hab     = 1'b0;

    case (r_estado)
      LIBRE: begin
        if (SolFetch || SolDato) begin
          if (SolFetch && SolDato) begin
            w_grant = ~r_ultimo;
          end else if (SolDato) begin
            w_grant = REQ_DATO;
          end else begin
            w_grant = REQ_FETCH;
          end
          if (w_grant == REQ_DATO) begin
            w_mem_dir      = DirDato;
            w_mem_esc      = EscDato;
            w_mem_dato_esc = DatoEsc;
          end else begin
            w_mem_dir      = DirFetch;
            w_mem_esc      = 1'b0;
            w_mem_dato_esc = '0;
          end
          w_mem_hab      = 1'b1;
          w_cont_limpiar = 1'b1;
          w_estado_sig   = ACCESO;
        end
      end

      ACCESO: begin
        if (MemListo || w_cont_terminal) begin
          if (MemListo && !r_mem_esc) begin
            w_dato_leido = MemDatoLeido;
          end else begin
            w_dato_leido = '0;
          end
          w_error      = !MemListo;
          w_mem_hab    = 1'b0;
          w_mem_esc    = 1'b0;
          w_ack_fetch  = (r_grant == REQ_FETCH);
          w_ack_dato   = (r_grant == REQ_DATO);
          w_estado_sig = RESPUESTA;
        end else begin
          w_cont_hab = 1'b1;
        end
      end

      RESPUESTA: begin
        w_ultimo     = r_grant;
        w_estado_sig = LIBRE;
      end

      default: begin
        w_estado_sig = LIBRE;
      end
    endcase
  end

  assign AckFetch   = r_ack_fetch;
  assign AckDato    = r_ack_dato;
  assign DatoLeido  = r_dato_leido;
  assign ErrorBus   = r_error;
  assign MemHab     = r_mem_hab;
  assign MemEsc     = r_mem_esc;
  assign MemDir     = r_mem_dir;
  assign MemDatoEsc = r_mem_dato_esc;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: reset, fetch read, wait-state write,
// round-robin alternation, timeout abort and reset during an access.
module tb_arbitro_memoria;

  logic        reloj = 1'b0;
  logic        reiniciar;
  logic        solFetch;
  logic [15:0] dirFetch;
  logic        ackFetch;
  logic        solDato;
  logic        escDato;
  logic [15:0] dirDato;
  logic [15:0] datoEsc;
  logic        ackDato;
  logic [15:0] datoLeido;
  logic        errorBus;
  logic        memHab;
  logic        memEsc;
  logic [15:0] memDir;
  logic [15:0] memDatoEsc;
  logic        memListo;
  logic [15:0] memDatoLeido;

  int errors = 0;
  int checks = 0;

  arbitro_memoria #(
    .ANCHO_DIR(16),
    .ANCHO_DATO(16),
    .LIMITE_ESPERA(15)
  ) dut (
    .Reloj(reloj),
    .Reiniciar(reiniciar),
    .SolFetch(solFetch),
    .DirFetch(dirFetch),
    .AckFetch(ackFetch),
    .SolDato(solDato),
    .EscDato(escDato),
    .DirDato(dirDato),
    .DatoEsc(datoEsc),
    .AckDato(ackDato),
    .DatoLeido(datoLeido),
    .ErrorBus(errorBus),
    .MemHab(memHab),
    .MemEsc(memEsc),
    .MemDir(memDir),
    .MemDatoEsc(memDatoEsc),
    .MemListo(memListo),
    .MemDatoLeido(memDatoLeido)
  );

  always #5 reloj = ~reloj;

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  task automatic test_reset();
    logic [68:0] allOut;
    reiniciar = 1'b0;
    solFetch = 1'b1;
    dirFetch = 16'h0ABC;
    solDato = 1'b0;
    escDato = 1'b0;
    dirDato = 16'h0000;
    datoEsc = 16'h0000;
    memListo = 1'b0;
    memDatoLeido = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      allOut = {ackFetch, ackDato, datoLeido, errorBus, memHab, memEsc, memDir, memDatoEsc};
      checks++;
      if (allOut !== 69'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %h expected 0", i, allOut);
      end
    end
    reiniciar = 1'b1;
    tick();
    checks++;
    if (memHab !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_memhab: got %b expected 1", memHab);
    end
    checks++;
    if (memDir !== 16'h0ABC) begin
      errors++;
      $display("[TB] FAIL reset_release_memdir: got %h expected 0abc", memDir);
    end
    memListo = 1'b1;
    tick();
    checks++;
    if (ackFetch !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ack: got %b expected 1", ackFetch);
    end
    solFetch = 1'b0;
    memListo = 1'b0;
    tick();
  endtask

  task automatic test_fetch_read();
    int ackCount = 0;
    int ackAt = 0;
    dirFetch = 16'h0010;
    memDatoLeido = 16'hA5C3;
    memListo = 1'b1;
    solFetch = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t == 1) begin
        checks++;
        if (memDir !== 16'h0010 || memHab !== 1'b1) begin
          errors++;
          $display("[TB] FAIL fetch_grant: got hab=%b dir=%h expected hab=1 dir=0010", memHab, memDir);
        end
      end
      if (ackFetch === 1'b1) begin
        ackCount++;
        ackAt = t;
        checks++;
        if (datoLeido !== 16'hA5C3 || errorBus !== 1'b0) begin
          errors++;
          $display("[TB] FAIL fetch_data: got dato=%h err=%b expected dato=a5c3 err=0", datoLeido, errorBus);
        end
        solFetch = 1'b0;
      end
    end
    checks++;
    if (ackCount != 1 || ackAt != 2) begin
      errors++;
      $display("[TB] FAIL fetch_ack_timing: got count=%0d at=%0d expected count=1 at=2", ackCount, ackAt);
    end
    memListo = 1'b0;
  endtask

  task automatic test_write_wait();
    int escCycles = 0;
    int ackAt = 0;
    solDato = 1'b1;
    escDato = 1'b1;
    dirDato = 16'h0200;
    datoEsc = 16'h1234;
    memDatoLeido = 16'hFFFF;
    memListo = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (memEsc === 1'b1 && memDatoEsc === 16'h1234 && memDir === 16'h0200 && memHab === 1'b1) escCycles++;
      if (ackDato === 1'b1) begin
        ackAt = t;
        checks++;
        if (datoLeido !== 16'h0000 || errorBus !== 1'b0) begin
          errors++;
          $display("[TB] FAIL write_result: got dato=%h err=%b expected dato=0000 err=0", datoLeido, errorBus);
        end
        solDato = 1'b0;
        escDato = 1'b0;
        memListo = 1'b0;
      end
      if (t == 4) memListo = 1'b1;
    end
    checks++;
    if (escCycles != 4) begin
      errors++;
      $display("[TB] FAIL write_strobe_cycles: got %0d expected 4", escCycles);
    end
    checks++;
    if (ackAt != 5) begin
      errors++;
      $display("[TB] FAIL write_ack_timing: got %0d expected 5", ackAt);
    end
    memListo = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ackCount = 0;
    int ackAt[4];
    logic ackWho[4];
    solFetch = 1'b1;
    solDato = 1'b1;
    escDato = 1'b0;
    dirFetch = 16'h0100;
    dirDato = 16'h0300;
    memDatoLeido = 16'h5A5A;
    memListo = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if ((ackFetch === 1'b1 || ackDato === 1'b1) && ackCount < 4) begin
        ackAt[ackCount] = t;
        ackWho[ackCount] = ackDato;
        ackCount++;
        if (ackCount == 4) begin
          solFetch = 1'b0;
          solDato = 1'b0;
        end
      end
    end
    checks++;
    if (ackCount != 4) begin
      errors++;
      $display("[TB] FAIL rr_ack_count: got %0d expected 4", ackCount);
    end
    for (int i = 0; i < ackCount; i++) begin
      checks++;
      if (ackWho[i] !== i[0] || ackAt[i] != 2 + 3 * i) begin
        errors++;
        $display("[TB] FAIL rr_grant_%0d: got dato=%b at=%0d expected dato=%b at=%0d", i, ackWho[i], ackAt[i], i[0], 2 + 3 * i);
      end
    end
    checks++;
    if (datoLeido !== 16'h5A5A) begin
      errors++;
      $display("[TB] FAIL rr_data: got %h expected 5a5a", datoLeido);
    end
    memListo = 1'b0;
  endtask

  task automatic test_timeout();
    int habCycles = 0;
    int ackAt = 0;
    solFetch = 1'b1;
    dirFetch = 16'h0040;
    memDatoLeido = 16'hBEEF;
    memListo = 1'b0;
    for (int t = 1; t <= 30 && ackAt == 0; t++) begin
      tick();
      if (memHab === 1'b1) habCycles++;
      if (ackFetch === 1'b1) begin
        ackAt = t;
        checks++;
        if (errorBus !== 1'b1 || datoLeido !== 16'h0000) begin
          errors++;
          $display("[TB] FAIL timeout_result: got err=%b dato=%h expected err=1 dato=0000", errorBus, datoLeido);
        end
        solFetch = 1'b0;
      end
    end
    checks++;
    if (ackAt != 16) begin
      errors++;
      $display("[TB] FAIL timeout_ack_timing: got %0d expected 16 (0 = no ack within bound)", ackAt);
    end
    checks++;
    if (habCycles != 15) begin
      errors++;
      $display("[TB] FAIL timeout_memhab_cycles: got %0d expected 15", habCycles);
    end
    solFetch = 1'b0;
    tick();
    checks++;
    if (errorBus !== 1'b0 || ackFetch !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_error_clear: got err=%b ack=%b expected 0 0", errorBus, ackFetch);
    end
  endtask

  task automatic test_reset_mid_access();
    solDato = 1'b1;
    escDato = 1'b0;
    dirDato = 16'h0444;
    memListo = 1'b0;
    tick();
    checks++;
    if (memHab !== 1'b1 || memDir !== 16'h0444) begin
      errors++;
      $display("[TB] FAIL midreset_grant: got hab=%b dir=%h expected hab=1 dir=0444", memHab, memDir);
    end
    tick();
    reiniciar = 1'b0;
    tick();
    checks++;
    if (memHab !== 1'b0 || ackDato !== 1'b0 || ackFetch !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_abandon: got hab=%b ackD=%b ackF=%b expected 0 0 0", memHab, ackDato, ackFetch);
    end
    reiniciar = 1'b1;
    solFetch = 1'b1;
    dirFetch = 16'h0888;
    tick();
    checks++;
    if (memHab !== 1'b1 || memDir !== 16'h0888 || ackDato !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_regrant: got hab=%b dir=%h ackD=%b expected hab=1 dir=0888 ackD=0", memHab, memDir, ackDato);
    end
    memListo = 1'b1;
    tick();
    checks++;
    if (ackFetch !== 1'b1 || ackDato !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_ack: got ackF=%b ackD=%b expected 1 0", ackFetch, ackDato);
    end
    solFetch = 1'b0;
    solDato = 1'b0;
    memListo = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_write_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
